mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported memory bus between the core's instruction-fetch port and its load/store port.
- Arbitrates between the two requesters, with data priority and an anti-starvation limit for fetch.
- Allows one outstanding transaction at a time and bounds each transaction with a response timeout.
- Turns bus completion into the core's stall and error signals: i_stall/i_fault towards IF, and data_stall/data_err towards MEM.

Parameters:
- AW, 32: address width.
- DW, 32: data width; byte-enable width is DW/8.
- MAX_STREAK, 4: maximum consecutive data grants while fetch is pending.
- TIMEOUT, 255: cycles allowed in WAIT_RSP or DRAIN before abort.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- i_req  in  1  fetch request; level, held until completion
- i_addr  in  AW  fetch address (pc_o)
- i_rdata  out  DW  fetch data; valid when i_req & ~i_stall
- i_stall  out  1  fetch not complete
- i_fault  out  1  fetch bus error or timeout; valid with completion
- d_req  in  1  data request (req_mem); level
- d_we  in  1  write enable (wmem_o)
- d_be  in  DW/8  byte mask (wmask)
- d_addr  in  AW  data address (addr_o)
- d_wdata  in  DW  store data (data_o)
- d_rdata  out  DW  load data (data_i)
- d_stall  out  1  data not complete (data_stall)
- d_err  out  1  data bus error or timeout (data_err)
- mem_req  out  1  bus request
- mem_we  out  1  bus write
- mem_be  out  DW/8  bus byte enables
- mem_addr  out  AW  bus address
- mem_wdata  out  DW  bus write data
- mem_gnt  in  1  bus accepts request this cycle
- mem_rvalid  in  1  response valid; at least 1 cycle after gnt
- mem_rdata  in  DW  response data
- mem_err  in  1  response error; qualified by mem_rvalid

Behaviour:
- States: IDLE, WAIT_GNT, WAIT_RSP, DRAIN.
- Reset (async) values:
  - State IDLE, owner NONE, streak=0, timer=0.
  - mem_req=0; captured payload registers = 0.
  - i_stall=i_req and d_stall=d_req (combinational); i_fault=d_err=0; rdata outputs=0.
- Arbitration (IDLE only):
  - Fetch wins if i_req & (~d_req | streak==MAX_STREAK).
  - Otherwise data wins if d_req.
- streak:
  - Increments on each data grant while i_req=1, saturating at MAX_STREAK.
  - Clears on a fetch grant, or in any cycle where i_req=0.
- IDLE with a winner:
  - mem_req=1; payload is driven combinationally from the winner and captured into payload registers the same cycle.
  - Fetch payload: mem_we=0, mem_be=all ones, mem_wdata=0.
  - mem_gnt=1 -> WAIT_RSP; mem_gnt=0 -> WAIT_GNT.
- WAIT_GNT:
  - mem_req=1 and payload come from the registers, held stable even if the owner drops its req; no re-arbitration.
  - On mem_gnt -> WAIT_RSP.
- WAIT_RSP:
  - mem_req=0; timer increments each cycle.
  - On mem_rvalid: completion to owner, then IDLE.
  - On timer==TIMEOUT without rvalid: abort completion (rdata=0, err=1), then DRAIN.
  - rvalid and timeout in the same cycle: rvalid wins.
- Completion cycle (combinational, 1 cycle):
  - Owner's stall=0 if its req is still high; rdata=mem_rdata; err/fault=mem_err.
  - Non-owner stall follows its req.
  - If the owner dropped its req, the response is discarded and err is suppressed.
- DRAIN:
  - Swallows one stray rvalid, or waits TIMEOUT further cycles, then IDLE; no grants meanwhile.
- Throughput: minimum 2 cycles per transaction (IDLE grant + WAIT_RSP). No back-to-back issue in a completion cycle; the next grant comes in the following IDLE cycle.
- Minimum latency: req -> completion in 2 cycles when gnt is immediate and rvalid comes 1 cycle after gnt.
- Timer: clears on entering WAIT_RSP and on entering DRAIN; width is clog2(TIMEOUT+1).
- Addresses pass through unmodified; no alignment checks.
- Reset asserted mid-transaction: immediate return to IDLE; a later stray rvalid in IDLE is ignored.

Decomposition:
- Package mem_arb_pkg:
  - State enum (IDLE, WAIT_GNT, WAIT_RSP, DRAIN).
  - Owner enum (NONE, FETCH, DATA).
  - Payload struct (we, be, addr, wdata).
- Sub-module mem_arb_timer: loadable clear/enable counter with expiry flag at TIMEOUT, used by WAIT_RSP and DRAIN.
- Arbitration and completion steering stay in the top module.

Test Plan:
- Single load, data only: d_req=1, d_addr=0x100, gnt same cycle, rvalid 1 cycle later with 0xDEADBEEF -> d_stall high 1 cycle; d_rdata=0xDEADBEEF, d_err=0 on cycle 2.
- Contention: i_req and d_req held continuously, MAX_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I; neither requester is starved.
- Delayed grant: store d_be=4'b0011, d_wdata=0x1234ABCD, gnt after 3 cycles, d_req dropped in cycle 2 -> mem_addr, mem_be and mem_wdata stable through all 3 cycles; response discarded, d_err=0.
- Timeout: fetch granted, no rvalid for 255 cycles -> i_fault=1, i_rdata=0, i_stall=0 on cycle 255; DRAIN then swallows a stray rvalid at cycle 260 without affecting a pending d_req, which is granted afterwards.
- Bus error: rvalid with mem_err=1 on a fetch -> i_fault=1 for exactly 1 cycle; d_req arriving meanwhile stays stalled until the next IDLE grant.
- Reset in WAIT_RSP: reset asserted -> mem_req=0 and state IDLE immediately; rvalid arriving after reset release is ignored and no completion is signalled.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// States, bus owner and the captured bus payload.
package mem_arb_pkg;

    localparam int ARB_AW = 32;
    localparam int ARB_DW = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RSP,
        DRAIN
    } state_t;

    typedef enum logic [1:0] {
        NONE,
        FETCH,
        DATA
    } owner_t;

    typedef struct packed {
        logic                  we;
        logic [ARB_DW/8-1:0]   be;
        logic [ARB_AW-1:0]     addr;
        logic [ARB_DW-1:0]     wdata;
    } payload_t;

endpackage

// File: rtl/mem_arb_timer.sv
// Response watchdog counter shared by WAIT_RSP and DRAIN.
// cnt holds the 1-based ordinal of the current cycle in the state.
module mem_arb_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] cnt;

    // Load 1 on state entry, then count up and saturate at TIMEOUT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= TW'(1);
        else if (en && cnt != TW'(TIMEOUT))
            cnt <= cnt + 1'b1;
    end

    assign expired = (cnt == TW'(TIMEOUT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between the fetch and load/store ports.
// Data has priority; fetch wins after MAX_STREAK data grants.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MAX_STREAK = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic [DW-1:0]   i_rdata,
    output logic            i_stall,
    output logic            i_fault,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic [DW-1:0]   d_rdata,
    output logic            d_stall,
    output logic            d_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_err
);

    localparam int SW = $clog2(MAX_STREAK + 1);

    state_t        state;
    owner_t        owner;
    logic [SW-1:0] streak;
    payload_t      pl_q;
    payload_t      pl_next;
    payload_t      pl_out;

    logic fetch_win;
    logic data_win;
    logic grant;
    logic rsp;
    logic abort;
    logic f_cpl;
    logic d_cpl;
    logic expired;
    logic tmr_clr;
    logic tmr_en;

    // Arbitration and the winner's payload (only acted on in IDLE).
    always_comb begin
        fetch_win = i_req & (~d_req | (streak == SW'(MAX_STREAK)));
        data_win  = d_req & ~fetch_win;
        grant     = (state == IDLE) & ~reset & (fetch_win | data_win);
        pl_next   = '0;
        if (fetch_win) begin
            pl_next.we    = 1'b0;
            pl_next.be    = '1;
            pl_next.addr  = i_addr;
            pl_next.wdata = '0;
        end else begin
            pl_next.we    = d_we;
            pl_next.be    = d_be;
            pl_next.addr  = d_addr;
            pl_next.wdata = d_wdata;
        end
    end

    // Bus side: live payload on the grant cycle, held copy afterwards.
    always_comb begin
        pl_out    = (state == IDLE) ? pl_next : pl_q;
        mem_req   = grant | (state == WAIT_GNT);
        mem_we    = pl_out.we;
        mem_be    = pl_out.be;
        mem_addr  = pl_out.addr;
        mem_wdata = pl_out.wdata;
    end

    // Completion steering; a requester that dropped its req gets nothing.
    always_comb begin
        rsp     = (state == WAIT_RSP) & mem_rvalid;
        abort   = (state == WAIT_RSP) & ~mem_rvalid & expired;
        f_cpl   = (rsp | abort) & (owner == FETCH) & i_req;
        d_cpl   = (rsp | abort) & (owner == DATA) & d_req;
        i_stall = i_req & ~f_cpl;
        d_stall = d_req & ~d_cpl;
        i_rdata = (f_cpl & rsp) ? mem_rdata : '0;
        d_rdata = (d_cpl & rsp) ? mem_rdata : '0;
        i_fault = f_cpl & (abort | mem_err);
        d_err   = d_cpl & (abort | mem_err);
        tmr_clr = (grant & mem_gnt)
                | ((state == WAIT_GNT) & mem_gnt)
                | abort;
        tmr_en  = (state == WAIT_RSP) | (state == DRAIN);
    end

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (expired)
    );

    // Transaction FSM, owner, payload capture and fetch starvation streak.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            owner  <= NONE;
            streak <= '0;
            pl_q   <= '0;
        end else begin
            if (!i_req || (grant && fetch_win))
                streak <= '0;
            else if (grant && streak != SW'(MAX_STREAK))
                streak <= streak + 1'b1;
            unique case (state)
                IDLE: begin
                    if (grant) begin
                        owner <= fetch_win ? FETCH : DATA;
                        pl_q  <= pl_next;
                        state <= mem_gnt ? WAIT_RSP : WAIT_GNT;
                    end
                end
                WAIT_GNT: begin
                    if (mem_gnt)
                        state <= WAIT_RSP;
                end
                WAIT_RSP: begin
                    if (mem_rvalid) begin
                        state <= IDLE;
                        owner <= NONE;
                    end else if (expired) begin
                        state <= DRAIN;
                        owner <= NONE;
                    end
                end
                DRAIN: begin
                    if (mem_rvalid || expired)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus
// random traffic compared each cycle against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int MAXS    = 4;
    localparam int TIMEOUT = 255;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req;
    logic [31:0]   i_addr;
    logic [31:0]   i_rdata;
    logic          i_stall;
    logic          i_fault;
    logic          d_req;
    logic          d_we;
    logic [3:0]    d_be;
    logic [31:0]   d_addr;
    logic [31:0]   d_wdata;
    logic [31:0]   d_rdata;
    logic          d_stall;
    logic          d_err;
    logic          mem_req;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [31:0]   mem_rdata;
    logic          mem_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .MAX_STREAK(MAXS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata),
        .i_stall(i_stall), .i_fault(i_fault),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_stall(d_stall),
        .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    int checks = 0;
    int errors = 0;

    // model: phase 0 free, 1 awaiting grant, 2 awaiting response, 3 draining
    int          m_phase = 0;
    int          m_who   = 0;
    int          m_ord   = 0;
    int          m_streak = 0;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;

    logic        s_mem_req, s_i_stall, s_i_fault, s_d_stall, s_d_err;
    logic [31:0] s_mem_addr, s_mem_wdata, s_i_rdata, s_d_rdata;
    logic [3:0]  s_mem_be;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against model mid-cycle, then advance model at the edge.
    task automatic tick();
        int          win;
        logic        e_req, e_we, done, tout, fd, dd;
        logic [3:0]  e_be;
        logic [31:0] e_addr, e_wd;
        #3;
        win = 0; e_req = 0; e_we = 0; e_be = 0; e_addr = 0; e_wd = 0;
        done = 0; tout = 0;
        if (!reset) begin
            case (m_phase)
                0: begin
                    if (i_req && (!d_req || m_streak >= MAXS)) win = 1;
                    else if (d_req) win = 2;
                    if (win == 1) begin
                        e_req = 1; e_we = 0; e_be = 4'hf;
                        e_addr = i_addr; e_wd = 0;
                    end else if (win == 2) begin
                        e_req = 1; e_we = d_we; e_be = d_be;
                        e_addr = d_addr; e_wd = d_wdata;
                    end
                end
                1: begin
                    e_req = 1; e_we = m_we; e_be = m_be;
                    e_addr = m_addr; e_wd = m_wdata;
                end
                2: begin
                    done = mem_rvalid || (m_ord == TIMEOUT);
                    tout = !mem_rvalid;
                end
                default: ;
            endcase
        end
        fd = done && m_who == 1 && i_req;
        dd = done && m_who == 2 && d_req;
        chk("mem_req", mem_req, e_req);
        if (e_req) begin
            chk("mem_we", mem_we, e_we);
            chk("mem_be", mem_be, e_be);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wd);
        end
        chk("i_stall", i_stall, i_req && !fd);
        chk("i_rdata", i_rdata, (fd && !tout) ? mem_rdata : 32'h0);
        chk("i_fault", i_fault, fd && (tout || mem_err));
        chk("d_stall", d_stall, d_req && !dd);
        chk("d_rdata", d_rdata, (dd && !tout) ? mem_rdata : 32'h0);
        chk("d_err", d_err, dd && (tout || mem_err));
        s_mem_req = mem_req; s_mem_addr = mem_addr; s_mem_be = mem_be;
        s_mem_wdata = mem_wdata; s_i_stall = i_stall; s_i_fault = i_fault;
        s_i_rdata = i_rdata; s_d_stall = d_stall; s_d_err = d_err;
        s_d_rdata = d_rdata;
        if (reset) begin
            m_phase = 0; m_who = 0; m_ord = 0; m_streak = 0;
        end else begin
            if (!i_req || win == 1) m_streak = 0;
            else if (win == 2 && m_streak < MAXS) m_streak++;
            case (m_phase)
                0: if (win != 0) begin
                    m_who = win; m_we = e_we; m_be = e_be;
                    m_addr = e_addr; m_wdata = e_wd;
                    m_phase = mem_gnt ? 2 : 1; m_ord = 1;
                end
                1: if (mem_gnt) begin m_phase = 2; m_ord = 1; end
                2: if (mem_rvalid) m_phase = 0;
                   else if (m_ord == TIMEOUT) begin m_phase = 3; m_ord = 1; end
                   else m_ord++;
                default: if (mem_rvalid || m_ord == TIMEOUT) m_phase = 0;
                         else m_ord++;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] exp_order;
        logic [9:0] order;
        int         n;
        reset = 1; i_req = 0; i_addr = 0; d_req = 1; d_we = 0;
        d_be = 4'hf; d_addr = 0; d_wdata = 0; mem_gnt = 1;
        mem_rvalid = 0; mem_rdata = 0; mem_err = 0;
        @(posedge clk); #1;
        tick();
        chk("rst_mem_req", s_mem_req, 0);
        chk("rst_d_stall", s_d_stall, 1);
        chk("rst_d_err", s_d_err, 0);
        reset = 0; d_req = 0;
        tick();
        chk("idle_i_stall", s_i_stall, 0);

        // single load
        d_req = 1; d_addr = 32'h100; mem_gnt = 1;
        tick();
        chk("ld_req", s_mem_req, 1);
        chk("ld_addr", s_mem_addr, 32'h100);
        chk("ld_stall0", s_d_stall, 1);
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
        tick();
        chk("ld_stall1", s_d_stall, 0);
        chk("ld_rdata", s_d_rdata, 32'hDEADBEEF);
        chk("ld_err", s_d_err, 0);
        d_req = 0; mem_rvalid = 0;
        tick();

        // contention ordering
        i_req = 1; i_addr = 32'h1000; d_req = 1; d_addr = 32'h2000;
        mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h11;
        exp_order = 10'b1000010000;
        order = '0; n = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (s_mem_req && n < 10) begin
                order[n] = (s_mem_addr == 32'h1000);
                n++;
            end
        end
        chk("cont_count", n, 10);
        for (int k = 0; k < 10; k++)
            chk($sformatf("cont_grant%0d", k), order[k], exp_order[k]);
        i_req = 0; d_req = 0; mem_rvalid = 0;
        tick();

        // delayed grant on a store, requester drops out
        d_req = 1; d_we = 1; d_be = 4'b0011; d_wdata = 32'h1234ABCD;
        d_addr = 32'h400; mem_gnt = 0;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) begin
                d_req = 0; d_addr = 32'hFFFF; d_wdata = 0; d_be = 4'hf;
            end
            mem_gnt = (c == 3);
            tick();
            chk("dg_req", s_mem_req, 1);
            chk("dg_addr", s_mem_addr, 32'h400);
            chk("dg_be", s_mem_be, 4'b0011);
            chk("dg_wdata", s_mem_wdata, 32'h1234ABCD);
        end
        mem_gnt = 0; mem_rvalid = 1; mem_err = 1; mem_rdata = 32'h77;
        tick();
        chk("dg_err", s_d_err, 0);
        chk("dg_rdata", s_d_rdata, 0);
        mem_rvalid = 0; mem_err = 0; d_we = 0; d_be = 4'hf;
        tick();

        // fetch timeout, drain, pending data granted afterwards
        i_req = 1; i_addr = 32'h500; mem_gnt = 1;
        for (int c = 0; c <= 262; c++) begin
            if (c == 100) begin d_req = 1; d_addr = 32'h600; end
            if (c == 256) i_req = 0;
            mem_rvalid = (c == 260) || (c == 262);
            mem_rdata = 32'hCAFE0000 + c;
            tick();
            if (c == 254) chk("to_stall254", s_i_stall, 1);
            if (c == 255) begin
                chk("to_stall", s_i_stall, 0);
                chk("to_fault", s_i_fault, 1);
                chk("to_rdata", s_i_rdata, 0);
            end
            if (c == 258) chk("to_drain_req", s_mem_req, 0);
            if (c == 261) begin
                chk("to_dgrant", s_mem_req, 1);
                chk("to_daddr", s_mem_addr, 32'h600);
            end
            if (c == 262) chk("to_ddone", s_d_stall, 0);
        end
        d_req = 0; mem_rvalid = 0;
        tick();

        // bus error on fetch while data arrives
        i_req = 1; i_addr = 32'h700; mem_gnt = 1;
        tick();
        mem_rvalid = 1; mem_err = 1; mem_rdata = 32'hBAD;
        d_req = 1; d_addr = 32'h800;
        tick();
        chk("be_fault", s_i_fault, 1);
        chk("be_dstall", s_d_stall, 1);
        i_req = 0; mem_rvalid = 0; mem_err = 0;
        tick();
        chk("be_fault_off", s_i_fault, 0);
        chk("be_dgrant", s_mem_addr, 32'h800);
        mem_rvalid = 1; mem_rdata = 32'h55;
        tick();
        chk("be_drdata", s_d_rdata, 32'h55);
        d_req = 0; mem_rvalid = 0;
        tick();

        // reset during WAIT_RSP
        d_req = 1; d_addr = 32'h900; mem_gnt = 1;
        tick();
        reset = 1;
        tick();
        chk("rs_req", s_mem_req, 0);
        chk("rs_dstall", s_d_stall, 1);
        reset = 0; d_req = 0; mem_rvalid = 1; mem_err = 1;
        mem_rdata = 32'hFFFF;
        tick();
        chk("rs_err", s_d_err, 0);
        chk("rs_rdata", s_d_rdata, 0);
        mem_rvalid = 0; mem_err = 0;
        tick();

        // random traffic
        for (int b = 0; b < 60; b++) begin
            bit quiet;
            int len;
            quiet = ($urandom % 6) == 0;
            len = quiet ? 300 : 40;
            for (int k = 0; k < len; k++) begin
                if ($urandom % 10 == 0) i_req = ~i_req;
                if ($urandom % 10 == 0) d_req = ~d_req;
                i_addr = $urandom; d_addr = $urandom; d_we = $urandom;
                d_be = $urandom; d_wdata = $urandom;
                mem_gnt = ($urandom % 10) < 6;
                mem_rvalid = quiet ? 1'b0 : (($urandom % 10) < 4);
                mem_err = ($urandom % 5) == 0;
                mem_rdata = $urandom;
                reset = ($urandom % 500) == 0;
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
